// File: rtl/clksel_ctrl_pkg.sv
// Shared types and constants for the clock-select controller.
package clksel_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_SETTLE = 2'd2,
    ST_REVERT = 2'd3
  } state_e;

  localparam logic [1:0] ERR_DEAD = 2'b01;
  localparam logic [1:0] ERR_LOST = 2'b10;

  // Number of bits needed to hold max_val (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((max_val >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/clksel_ctrl_sync.sv
// Two-flop synchronizer for one asynchronous liveness flag, reset to 0.
module clksel_sync2 (
  input  logic clk0,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // Next values simply shift the input through the chain.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clksel_ctrl.sv
// Clock-select controller: drives a 4:1 glitch-free mux select, waits a
// settle period after each change and reverts if the new source dies.
// Optional autonomous fallback to source 0: define CLKSEL_CTRL_FALLBACK_EN.
module clksel_ctrl
  import clksel_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic       clk0,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  input  logic [3:0] clk_ok,
  output logic [1:0] sel,
  output logic [1:0] cur_sel,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       fb
);

  localparam int unsigned    CW       = cnt_width(SETTLE_CYC - 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE_CYC - 1);

  logic [3:0] ok_s;

  for (genvar g = 0; g < 4; g++) begin : g_sync
    clksel_sync2 u_sync (
      .clk0  (clk0),
      .rst_n (rst_n),
      .d     (clk_ok[g]),
      .q     (ok_s[g])
    );
  end

  state_e        state_d, state_q;
  logic [1:0]    sel_d, sel_q;
  logic [1:0]    cur_sel_d, cur_sel_q;
  logic [1:0]    tgt_d, tgt_q;
  logic [1:0]    prev_d, prev_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          done_d, done_q;
  logic          err_d, err_q;
  logic [1:0]    err_code_d, err_code_q;
  logic          fb_go;

`ifdef CLKSEL_CTRL_FALLBACK_EN
  logic fb_d, fb_q;

  assign fb_go = (cur_sel_q != 2'd0) && !ok_s[cur_sel_q];

  // Fallback pulse: idle, no request this cycle, committed source lost.
  always_comb begin
    fb_d = (state_q == ST_IDLE) && !req_valid && fb_go;
  end

  // Fallback pulse register.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) fb_q <= 1'b0;
    else        fb_q <= fb_d;
  end

  assign fb = fb_q;
`else
  assign fb_go = 1'b0;
  assign fb    = 1'b0;
`endif

  // Next-state and registered-output logic for the switch sequence.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cur_sel_d  = cur_sel_q;
    tgt_d      = tgt_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_sel == cur_sel_q) begin
            done_d = 1'b1;
          end else if (!ok_s[req_sel]) begin
            err_d      = 1'b1;
            err_code_d = ERR_DEAD;
          end else begin
            tgt_d   = req_sel;
            prev_d  = cur_sel_q;
            state_d = ST_SWITCH;
          end
        end else if (fb_go) begin
          // Fallback target 0 is taken without a liveness check.
          tgt_d   = 2'd0;
          prev_d  = cur_sel_q;
          state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        sel_d   = tgt_q;
        cnt_d   = CNT_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!ok_s[tgt_q]) begin
          sel_d   = prev_q;
          cnt_d   = CNT_LOAD;
          state_d = ST_REVERT;
        end else if (cnt_q == '0) begin
          cur_sel_d = tgt_q;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_REVERT: begin
        if (cnt_q == '0) begin
          err_d      = 1'b1;
          err_code_d = ERR_LOST;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers; reset aborts any switch in progress.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      cur_sel_q  <= '0;
      tgt_q      <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cur_sel_q  <= cur_sel_d;
      tgt_q      <= tgt_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign sel       = sel_q;
  assign cur_sel   = cur_sel_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_clksel_ctrl.sv
// Self-checking bench for clksel_ctrl: timeline model plus directed scenarios
// and a randomized phase.
`timescale 1ns/1ps
module tb_clksel_ctrl;

  localparam int unsigned S = 16;

  logic       clk0 = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_sel = 2'd0;
  logic [3:0] clk_ok = 4'hF;
  logic       req_ready, busy, done, err, fb;
  logic [1:0] sel, cur_sel, err_code;

  int errors = 0;
  int checks = 0;

  clksel_ctrl #(.SETTLE_CYC(S)) dut (
    .clk0      (clk0),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .clk_ok    (clk_ok),
    .sel       (sel),
    .cur_sel   (cur_sel),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .fb        (fb)
  );

  always #5 clk0 = ~clk0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Timeline model: edge numbers of acceptance / loss decide every output.
  int         cyc = 0;
  bit         m_busy;
  int         m_a, m_fail;
  logic [1:0] m_tgt, m_prev, m_cur, m_sel, m_code;
  bit         m_done, m_err, m_fb;
  logic [3:0] h1, h2, oks;
  bit         fb_seen = 1'b0;

  always @(posedge clk0) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_a = 0; m_fail = -1;
      m_tgt = 0; m_prev = 0; m_cur = 0; m_sel = 0; m_code = 0;
      m_done = 0; m_err = 0; m_fb = 0;
      h1 = 0; h2 = 0;
    end else begin
      // liveness seen by the controller at this edge = clk_ok two edges ago
      oks = h2; h2 = h1; h1 = clk_ok;
      m_done = 0; m_err = 0; m_fb = 0;
      if (m_busy) begin
        if (m_fail < 0) begin
          if (cyc >= m_a + 2 && !oks[m_tgt]) begin
            m_fail = cyc; m_sel = m_prev;
          end else if (cyc == m_a + 1 + S) begin
            m_busy = 0; m_cur = m_tgt; m_done = 1;
          end else if (cyc == m_a + 1) begin
            m_sel = m_tgt;
          end
        end else if (cyc == m_fail + S) begin
          m_busy = 0; m_err = 1; m_code = 2'b10;
        end
      end else if (req_valid) begin
        if (req_sel == m_cur) m_done = 1;
        else if (!oks[req_sel]) begin m_err = 1; m_code = 2'b01; end
        else begin m_busy = 1; m_a = cyc; m_fail = -1; m_tgt = req_sel; m_prev = m_cur; end
      end
`ifdef CLKSEL_CTRL_FALLBACK_EN
      else if (m_cur != 0 && !oks[m_cur]) begin
        m_fb = 1; m_busy = 1; m_a = cyc; m_fail = -1; m_tgt = 0; m_prev = m_cur;
      end
`endif
    end
  end

  // Every out-of-reset cycle, DUT outputs must match the model.
  always @(negedge clk0) begin
    if (rst_n) begin
      chk("sel", sel, m_sel);
      chk("cur_sel", cur_sel, m_cur);
      chk("busy", busy, m_busy);
      chk("req_ready", req_ready, !m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("err_code", err_code, m_code);
      chk("fb", fb, m_fb);
      if (fb) fb_seen = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk0);
      #2;
    end
  endtask

  // Present a one-cycle request; returns just after the acceptance edge.
  task automatic req(input logic [1:0] s);
    req_valid = 1'b1; req_sel = s;
    step(1);
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_ok = 4'hF;
    step(4);
    chk("rst_sel", sel, 0);
    chk("rst_cur_sel", cur_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_err_code", err_code, 0);
    rst_n = 1'b1;
    step(3);

    // dead target
    clk_ok = 4'b1011; step(3);
    req(2);
    chk("dead_err", err, 1);
    chk("dead_code", err_code, 1);
    chk("dead_sel", sel, 0);
    chk("dead_cur", cur_sel, 0);

    // target lost mid-settle
    clk_ok = 4'hF; step(3);
    req(3);
    step(1); chk("lost_sel_new", sel, 3);
    step(4); clk_ok = 4'b0111;
    step(2); chk("lost_sel_hold", sel, 3);
    step(1); chk("lost_sel_back", sel, 0); chk("lost_busy", busy, 1);
    step(15); chk("lost_err_early", err, 0);
    step(1); chk("lost_err", err, 1); chk("lost_code", err_code, 2);
    chk("lost_cur", cur_sel, 0);

    // normal switch to 2
    clk_ok = 4'hF; step(3);
    req(2);
    chk("sw_sel_early", sel, 0);
    step(1); chk("sw_sel", sel, 2);
    step(15); chk("sw_done_early", done, 0);
    step(1); chk("sw_done", done, 1); chk("sw_cur", cur_sel, 2); chk("sw_busy", busy, 0);

    // request equal to current
    req(2);
    chk("same_done", done, 1); chk("same_busy", busy, 0); chk("same_sel", sel, 2);
    step(1); chk("same_done_off", done, 0); chk("same_sel2", sel, 2);

    // requests while busy are dropped
    req_valid = 1'b1; req_sel = 2'd1;
    step(1);
    req_sel = 2'd3;
    step(5); req_valid = 1'b0;
    step(12); chk("busy_done", done, 1); chk("busy_cur", cur_sel, 1); chk("busy_sel", sel, 1);
    step(1); chk("busy_no_more", busy, 0); chk("busy_cur2", cur_sel, 1);

    // committed source 1 dies while idle
    clk_ok = 4'b1101; step(6);
`ifdef CLKSEL_CTRL_FALLBACK_EN
    step(20);
    chk("fb_seen", fb_seen, 1); chk("fb_sel", sel, 0); chk("fb_cur", cur_sel, 0);
`else
    chk("nofb_seen", fb_seen, 0); chk("nofb_sel", sel, 1); chk("nofb_cur", cur_sel, 1);
`endif

    // reset mid-settle
    clk_ok = 4'hF; step(3);
    req(2);
    step(8);
    rst_n = 1'b0; #1;
    chk("arst_sel", sel, 0); chk("arst_cur", cur_sel, 0); chk("arst_busy", busy, 0);
    chk("arst_ready", req_ready, 1); chk("arst_done", done, 0); chk("arst_err", err, 0);
    chk("arst_fb", fb, 0); chk("arst_code", err_code, 0);
    step(2); rst_n = 1'b1; step(3);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0)
        for (int b = 0; b < 4; b++) clk_ok[b] = ($urandom_range(0, 99) < 85);
      req_valid = ($urandom_range(0, 3) == 0);
      req_sel   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0; step(2); rst_n = 1'b1;
      end
      step(1);
    end
    req_valid = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
